// File: rtl/operand_sequencer.sv
// Operand entry sequencer: loads A, B and an op code from switches, then strobes the datapath.
// Optional button debounce is enabled with the OPSEQ_DEBOUNCE_EN macro.
module operand_sequencer #(
    parameter int unsigned N          = 4,
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw,
    input  logic [3:0]   sw_op,
    input  logic         btn_enter,
    input  logic         btn_clear,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic [3:0]   operacion,
    output logic         op_valid,
    output logic [N-1:0] result_reg,
    output logic [3:0]   flags_reg,
    output logic [2:0]   estado,
    output logic         done,
    output logic         op_err
);

    typedef enum logic [2:0] {
        CargaA  = 3'd0,
        CargaB  = 3'd1,
        CargaOp = 3'd2,
        Ejecuta = 3'd3,
        Muestra = 3'd4
    } state_e;

    state_e      state_q;
    logic [1:0]  ent_sync_q, clr_sync_q;
    logic        ent_lvl, clr_lvl;
    logic        ent_prev_q, clr_prev_q;
    logic        enter_p_q, clear_p_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_sync_q <= '0;
            clr_sync_q <= '0;
        end else begin
            ent_sync_q <= {ent_sync_q[0], btn_enter};
            clr_sync_q <= {clr_sync_q[0], btn_clear};
        end
    end

`ifdef OPSEQ_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);

    logic [CntW-1:0] ent_cnt_q, clr_cnt_q;
    logic            ent_deb_q, clr_deb_q;

    // A level change is accepted once the new value has been seen DEB_CYCLES times in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_cnt_q <= '0;
            clr_cnt_q <= '0;
            ent_deb_q <= 1'b0;
            clr_deb_q <= 1'b0;
        end else begin
            if (ent_sync_q[1] == ent_deb_q) begin
                ent_cnt_q <= '0;
            end else if (ent_cnt_q == CntW'(DEB_CYCLES - 1)) begin
                ent_cnt_q <= '0;
                ent_deb_q <= ent_sync_q[1];
            end else begin
                ent_cnt_q <= ent_cnt_q + 1'b1;
            end
            if (clr_sync_q[1] == clr_deb_q) begin
                clr_cnt_q <= '0;
            end else if (clr_cnt_q == CntW'(DEB_CYCLES - 1)) begin
                clr_cnt_q <= '0;
                clr_deb_q <= clr_sync_q[1];
            end else begin
                clr_cnt_q <= clr_cnt_q + 1'b1;
            end
        end
    end

    assign ent_lvl = ent_deb_q;
    assign clr_lvl = clr_deb_q;
`else
    assign ent_lvl = ent_sync_q[1];
    assign clr_lvl = clr_sync_q[1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_prev_q <= 1'b0;
            clr_prev_q <= 1'b0;
            enter_p_q  <= 1'b0;
            clear_p_q  <= 1'b0;
        end else begin
            ent_prev_q <= ent_lvl;
            clr_prev_q <= clr_lvl;
            enter_p_q  <= ent_lvl & ~ent_prev_q;
            clear_p_q  <= clr_lvl & ~clr_prev_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CargaA;
            a          <= '0;
            b          <= '0;
            operacion  <= '0;
            result_reg <= '0;
            flags_reg  <= '0;
            op_valid   <= 1'b0;
            done       <= 1'b0;
            op_err     <= 1'b0;
        end else begin
            op_valid <= 1'b0;
            op_err   <= 1'b0;
            if (clear_p_q) begin
                state_q    <= CargaA;
                a          <= '0;
                b          <= '0;
                operacion  <= '0;
                result_reg <= '0;
                flags_reg  <= '0;
                done       <= 1'b0;
            end else begin
                unique case (state_q)
                    CargaA: if (enter_p_q) begin
                        a       <= sw;
                        state_q <= CargaB;
                    end
                    CargaB: if (enter_p_q) begin
                        b       <= sw;
                        state_q <= CargaOp;
                    end
                    CargaOp: if (enter_p_q) begin
                        if (sw_op <= 4'd9) begin
                            operacion <= sw_op;
                            op_valid  <= 1'b1;
                            state_q   <= Ejecuta;
                        end else begin
                            op_err <= 1'b1;
                        end
                    end
                    Ejecuta: begin
                        result_reg <= alu_result;
                        flags_reg  <= alu_flags;
                        done       <= 1'b1;
                        state_q    <= Muestra;
                    end
                    Muestra: if (enter_p_q) begin
                        done    <= 1'b0;
                        state_q <= CargaA;
                    end
                    default: state_q <= CargaA;
                endcase
            end
        end
    end

    assign estado = state_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed self-checking bench for operand_sequencer with a simple adder standing in for the ALU.
module tb_operand_sequencer;

    localparam int N   = 4;
    localparam int DEB = 4;
`ifdef OPSEQ_DEBOUNCE_EN
    localparam int Lat = 3 + DEB;
`else
    localparam int Lat = 3;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] sw;
    logic [3:0]   sw_op;
    logic         btn_enter, btn_clear;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;
    logic [N-1:0] a, b, result_reg;
    logic [3:0]   operacion, flags_reg;
    logic         op_valid, done, op_err;
    logic [2:0]   estado;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Datapath stand-in: result is a+b, flags echo the op code.
    assign alu_result = a + b;
    assign alu_flags  = operacion;

    operand_sequencer #(.N(N), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .sw(sw), .sw_op(sw_op),
        .btn_enter(btn_enter), .btn_clear(btn_clear),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .a(a), .b(b), .operacion(operacion), .op_valid(op_valid),
        .result_reg(result_reg), .flags_reg(flags_reg),
        .estado(estado), .done(done), .op_err(op_err)
    );

    // Hold the chosen buttons until the FSM has reacted, then sample.
    task automatic press(input logic ent, input logic clr);
        @(negedge clk);
        btn_enter = ent;
        btn_clear = clr;
        repeat (Lat + 1) @(posedge clk);
        #1;
    endtask

    task automatic release_btns();
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (Lat + 1) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (estado !== 3'd0) begin errors++; $display("FAIL reset_estado got %0d exp 0", estado); end
        checks++; if (a !== 4'd0 || b !== 4'd0) begin errors++; $display("FAIL reset_ab got %0d/%0d exp 0/0", a, b); end
        checks++; if (operacion !== 4'd0) begin errors++; $display("FAIL reset_op got %0d exp 0", operacion); end
        checks++; if (result_reg !== 4'd0 || flags_reg !== 4'd0) begin errors++; $display("FAIL reset_res got %0d/%0d exp 0/0", result_reg, flags_reg); end
        checks++; if ({op_valid, done, op_err} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b exp 000", {op_valid, done, op_err}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        sw = 4'd3;
        @(negedge clk);
        btn_enter = 1'b1;
        repeat (Lat) @(posedge clk);
        #1;
        checks++; if (estado !== 3'd0) begin errors++; $display("FAIL latency_early got %0d exp 0", estado); end
        @(posedge clk);
        #1;
        checks++; if (estado !== 3'd1 || a !== 4'd3) begin errors++; $display("FAIL load_a got st=%0d a=%0d exp st=1 a=3", estado, a); end
        release_btns();
        sw = 4'd5;
        press(1'b1, 1'b0);
        checks++; if (estado !== 3'd2 || b !== 4'd5) begin errors++; $display("FAIL load_b got st=%0d b=%0d exp st=2 b=5", estado, b); end
        release_btns();
        sw_op = 4'd0;
        press(1'b1, 1'b0);
        checks++; if (estado !== 3'd3 || op_valid !== 1'b1) begin errors++; $display("FAIL exec got st=%0d v=%b exp st=3 v=1", estado, op_valid); end
        checks++; if (a !== 4'd3 || b !== 4'd5 || operacion !== 4'd0) begin errors++; $display("FAIL exec_opnds got %0d %0d %0d exp 3 5 0", a, b, operacion); end
        @(posedge clk);
        #1;
        checks++; if (op_valid !== 1'b0 || done !== 1'b1 || estado !== 3'd4) begin errors++; $display("FAIL show got v=%b d=%b st=%0d exp v=0 d=1 st=4", op_valid, done, estado); end
        checks++; if (result_reg !== 4'd8 || flags_reg !== 4'd0) begin errors++; $display("FAIL result got %0d/%0d exp 8/0", result_reg, flags_reg); end
        release_btns();
        checks++; if (estado !== 3'd4 || result_reg !== 4'd8) begin errors++; $display("FAIL hold_show got st=%0d r=%0d exp 4/8", estado, result_reg); end
        press(1'b1, 1'b0);
        checks++; if (estado !== 3'd0 || done !== 1'b0 || result_reg !== 4'd8) begin errors++; $display("FAIL back_a got st=%0d d=%b r=%0d exp 0/0/8", estado, done, result_reg); end
        release_btns();
    endtask

    task automatic test_bad_op();
        sw = 4'd2; press(1'b1, 1'b0); release_btns();
        sw = 4'd6; press(1'b1, 1'b0); release_btns();
        sw_op = 4'd12;
        press(1'b1, 1'b0);
        checks++; if (op_err !== 1'b1 || estado !== 3'd2 || operacion !== 4'd0) begin errors++; $display("FAIL bad_op got e=%b st=%0d op=%0d exp 1/2/0", op_err, estado, operacion); end
        @(posedge clk);
        #1;
        checks++; if (op_err !== 1'b0 || estado !== 3'd2) begin errors++; $display("FAIL bad_op_pulse got e=%b st=%0d exp 0/2", op_err, estado); end
        release_btns();
        sw_op = 4'd1;
        press(1'b1, 1'b0);
        checks++; if (estado !== 3'd3 || operacion !== 4'd1) begin errors++; $display("FAIL good_op got st=%0d op=%0d exp 3/1", estado, operacion); end
        @(posedge clk);
        #1;
        checks++; if (result_reg !== 4'd8 || flags_reg !== 4'd1) begin errors++; $display("FAIL good_res got %0d/%0d exp 8/1", result_reg, flags_reg); end
        release_btns();
        press(1'b1, 1'b0); release_btns();
    endtask

    task automatic test_clear();
        sw = 4'd7; press(1'b1, 1'b0); release_btns();
        sw = 4'd2; press(1'b1, 1'b0); release_btns();
        checks++; if (estado !== 3'd2 || a !== 4'd7 || b !== 4'd2) begin errors++; $display("FAIL pre_clear got st=%0d a=%0d b=%0d exp 2/7/2", estado, a, b); end
        press(1'b0, 1'b1);
        checks++; if (estado !== 3'd0 || a !== 4'd0 || b !== 4'd0 || operacion !== 4'd0 || result_reg !== 4'd0) begin errors++; $display("FAIL clear got st=%0d a=%0d b=%0d op=%0d r=%0d exp all 0", estado, a, b, operacion, result_reg); end
        release_btns();
        sw = 4'd4; press(1'b1, 1'b0); release_btns();
        press(1'b1, 1'b1);
        checks++; if (estado !== 3'd0 || a !== 4'd0) begin errors++; $display("FAIL clear_wins got st=%0d a=%0d exp 0/0", estado, a); end
        release_btns();
    endtask

    task automatic test_reset_in_exec();
        sw = 4'd1; press(1'b1, 1'b0); release_btns();
        press(1'b1, 1'b0); release_btns();
        sw_op = 4'd2;
        press(1'b1, 1'b0);
        checks++; if (estado !== 3'd3) begin errors++; $display("FAIL pre_rst got st=%0d exp 3", estado); end
        rst = 1'b1;
        btn_enter = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (estado !== 3'd0 || op_valid !== 1'b0 || result_reg !== 4'd0 || done !== 1'b0) begin errors++; $display("FAIL rst_exec got st=%0d v=%b r=%0d d=%b exp 0/0/0/0", estado, op_valid, result_reg, done); end
        repeat (Lat) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (Lat + 1) @(posedge clk);
        #1;
        checks++; if (estado !== 3'd0 || a !== 4'd0) begin errors++; $display("FAIL post_rst got st=%0d a=%0d exp 0/0", estado, a); end
    endtask

    task automatic test_hold();
        int changes;
        logic [2:0] prev;
        changes = 0;
        sw = 4'd9;
        @(negedge clk);
        btn_enter = 1'b1;
        prev = estado;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (estado !== prev) changes++;
            prev = estado;
        end
        checks++; if (changes !== 1) begin errors++; $display("FAIL hold_changes got %0d exp 1", changes); end
        checks++; if (estado !== 3'd1 || a !== 4'd9) begin errors++; $display("FAIL hold_state got st=%0d a=%0d exp 1/9", estado, a); end
        release_btns();
    endtask

`ifdef OPSEQ_DEBOUNCE_EN
    task automatic test_glitch();
        @(negedge clk);
        btn_enter = 1'b1;
        repeat (2) @(negedge clk);
        btn_enter = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checks++; if (estado !== 3'd1) begin errors++; $display("FAIL glitch got st=%0d exp 1", estado); end
        sw = 4'd3;
        press(1'b1, 1'b0);
        checks++; if (estado !== 3'd2 || b !== 4'd3) begin errors++; $display("FAIL deb_press got st=%0d b=%0d exp 2/3", estado, b); end
        release_btns();
    endtask
`endif

    initial begin
        rst = 1'b1; sw = '0; sw_op = '0; btn_enter = 1'b0; btn_clear = 1'b0;
        test_reset();
        test_basic();
        test_bad_op();
        test_clear();
        test_reset_in_exec();
        test_hold();
`ifdef OPSEQ_DEBOUNCE_EN
        test_glitch();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have parameter N, default 4, giving operand and result width in bits.
REQ-002 SHALL have parameter DEB_CYCLES, default 16, giving the debounce stable-count (used only under REQ-031).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sw  input  N  operand entry switches.
REQ-006 sw_op  input  4  operation code entry switches.
REQ-007 btn_enter  input  1  raw, asynchronous enter button, active-high.
REQ-008 btn_clear  input  1  raw, asynchronous clear button, active-high.
REQ-009 alu_result  input  N  result returned by the calculator datapath (combinational).
REQ-010 alu_flags  input  4  flags returned by the calculator datapath.
REQ-011 a, b  output  N each  registered operands driven to the datapath.
REQ-012 operacion  output  4  registered operation code driven to the datapath.
REQ-013 op_valid  output  1  one-cycle execute strobe.
REQ-014 result_reg  output  N  captured result; flags_reg  output  4  captured flags.
REQ-015 estado  output  3  current FSM state encoding; done  output  1  result held; op_err  output  1  one-cycle invalid-op pulse.

Function
REQ-016 btn_enter and btn_clear SHALL each pass a 2-flop synchronizer, then a rising-edge detector producing a one-cycle enter_p / clear_p.
REQ-017 With the macro off, enter_p SHALL assert on the 3rd rising clk edge at which btn_enter is sampled high, for exactly one cycle per press.
REQ-018 FSM states and encoding: CARGA_A=0, CARGA_B=1, CARGA_OP=2, EJECUTA=3, MUESTRA=4; estado SHALL equal the encoding.
REQ-019 CARGA_A + enter_p: a <= sw, go CARGA_B.
REQ-020 CARGA_B + enter_p: b <= sw, go CARGA_OP.
REQ-021 CARGA_OP + enter_p with sw_op <= 9: operacion <= sw_op, go EJECUTA.
REQ-022 CARGA_OP + enter_p with sw_op > 9: op_err pulses one cycle, operacion unchanged, remain CARGA_OP.
REQ-023 EJECUTA SHALL last exactly one cycle with op_valid=1; at its end result_reg <= alu_result and flags_reg <= alu_flags; go MUESTRA.
REQ-024 MUESTRA: done=1; result_reg/flags_reg/a/b/operacion held; enter_p returns to CARGA_A without clearing result_reg.
REQ-025 op_valid SHALL be 0 in every state except EJECUTA; done SHALL be 1 only in MUESTRA.
REQ-026 clear_p in any state SHALL zero a, b, operacion, result_reg and flags_reg and go CARGA_A next cycle.
REQ-027 clear_p and enter_p in the same cycle: clear wins, the enter is discarded.
REQ-028 enter_p arriving in EJECUTA SHALL be ignored; capture still completes.
REQ-029 No arithmetic in this block; all widths pass through unmodified, no truncation or extension.

Reset
REQ-030 rst high at a rising edge SHALL set state CARGA_A, a=b=0, operacion=0, result_reg=0, flags_reg=0, op_valid=0, done=0, op_err=0, and clear synchronizer, edge and debounce registers, including when asserted during EJECUTA.

Configuration
REQ-031 Macro OPSEQ_DEBOUNCE_EN defined: each synchronized button SHALL be accepted only after DEB_CYCLES consecutive equal samples, edge detection acting on the debounced level; enter_p latency becomes 3+DEB_CYCLES cycles.
REQ-032 Macro OPSEQ_DEBOUNCE_EN undefined: no debounce logic; behaviour per REQ-017.

Verification
REQ-033 Macro off; sw=3, enter; sw=5, enter; sw_op=0, enter -> op_valid one cycle with a=3,b=5,operacion=0; alu_result=8,alu_flags=0 -> result_reg=8, done=1, estado=4.
REQ-034 In CARGA_OP, sw_op=12, enter -> op_err one cycle, estado stays 2; then sw_op=1, enter -> estado=3 next.
REQ-035 btn_clear pressed in CARGA_OP with a=7,b=2 -> a=b=operacion=0, estado=0; simultaneous enter+clear -> estado=0.
REQ-036 rst asserted during EJECUTA -> next cycle estado=0, op_valid=0, result_reg=0.
REQ-037 btn_enter held high 20 cycles -> exactly one enter_p, one state advance.
REQ-038 Macro on, DEB_CYCLES=4; 2-cycle glitch on btn_enter -> no advance; clean press -> advance after 7 cycles.
